opto_switch_filter_mc: RTL

//  Multi-channel debounce filter for opto-switch inputs (zero-index, limit and encoder-gap sensors) in the rotate path.

---
 rtl/opto_switch_filter_mc_pkg.sv | 13 +
 rtl/opto_switch_filter_mc_ch.sv | 95 +++++++++
 rtl/opto_switch_filter_mc.sv | 42 ++++
 3 files changed

// File: rtl/opto_switch_filter_mc_pkg.sv
// Shared defaults for the opto-switch debounce filter.
package opto_switch_filter_mc_pkg;

  // Stability counter / threshold width.
  localparam int CNT_W_DEF = 16;

  // Per-channel glitch counter width.
  localparam int GLITCH_W_DEF = 8;

  // Default stability threshold in clocks. The integrating level drives this onto i_thresh.
  localparam logic [15:0] DEF_OPTO_THRESH = 16'd500;

endpackage

// File: rtl/opto_switch_filter_mc_ch.sv
// One debounce channel: 2-FF synchroniser, stability counter, filtered level,
// rise/fall strobes and a saturating count of rejected glitches.
import opto_switch_filter_mc_pkg::*;

module opto_switch_filter_ch #(
  parameter int   CNT_W      = CNT_W_DEF,
  parameter logic INIT_LEVEL = 1'b0,
  parameter int   GLITCH_W   = GLITCH_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [CNT_W-1:0]    i_thresh,
  input  logic                i_raw,
  input  logic                i_glitch_clr,
  output logic                o_level,
  output logic                o_rise,
  output logic                o_fall,
  output logic [GLITCH_W-1:0] o_glitch_cnt
);

  logic                r_s1;
  logic                r_s2;
  logic                r_out;
  logic                r_rise;
  logic                r_fall;
  logic [CNT_W-1:0]    r_cnt;
  logic [GLITCH_W-1:0] r_glitch;

  logic [CNT_W-1:0]    w_eff_thr;
  logic                w_qualify;
  logic                w_update;
  logic                w_glitch;

  // A zero threshold behaves like a threshold of one clock.
  assign w_eff_thr = (i_thresh == '0) ? CNT_W'(1) : i_thresh;

  // s2 has been stable for at least eff_thr clocks.
  assign w_qualify = (r_cnt >= w_eff_thr);
  assign w_update  = w_qualify && (r_s2 != r_out);

  // Input moved back to the filtered level before the excursion qualified.
  assign w_glitch  = (r_s1 != r_s2) && (r_s1 == r_out) && !w_qualify;

  // Two-stage synchroniser for the asynchronous sensor level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= INIT_LEVEL;
      r_s2 <= INIT_LEVEL;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // Stability counter: restarts on any change, otherwise counts up and saturates.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_s1 != r_s2) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Filtered level follows s2 once qualified; strobes fire on the same edge for one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out  <= INIT_LEVEL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_update &&  r_s2;
      r_fall <= w_update && !r_s2;
      if (w_update) begin
        r_out <= r_s2;
      end
    end
  end

  // Glitch counter: clear wins over a simultaneous increment; saturates at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_glitch_clr) begin
      r_glitch <= '0;
    end else if (w_glitch && (r_glitch != '1)) begin
      r_glitch <= r_glitch + GLITCH_W'(1);
    end
  end

  assign o_level      = r_out;
  assign o_rise       = r_rise;
  assign o_fall       = r_fall;
  assign o_glitch_cnt = r_glitch;

endmodule

// File: rtl/opto_switch_filter_mc.sv
// Multi-channel debounce filter for opto-switch sensors in the rotate path.
// Interface: no handshake. Every output is registered; i_thresh and
// i_glitch_clr are shared by all channels and take effect at the next edge.
import opto_switch_filter_mc_pkg::*;

module opto_switch_filter_mc #(
  parameter int   CH_NUM     = 4,
  parameter int   CNT_W      = CNT_W_DEF,
  parameter logic INIT_LEVEL = 1'b0,
  parameter int   GLITCH_W   = GLITCH_W_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [CNT_W-1:0]           i_thresh,
  input  logic [CH_NUM-1:0]          i_opto_switch,
  input  logic                       i_glitch_clr,
  output logic [CH_NUM-1:0]          o_opto_switch,
  output logic [CH_NUM-1:0]          o_rise,
  output logic [CH_NUM-1:0]          o_fall,
  output logic [CH_NUM*GLITCH_W-1:0] o_glitch_cnt
);

  // One independent filter per channel; channel n's glitch count sits at [n*GLITCH_W +: GLITCH_W].
  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    opto_switch_filter_ch #(
      .CNT_W      (CNT_W),
      .INIT_LEVEL (INIT_LEVEL),
      .GLITCH_W   (GLITCH_W)
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_thresh     (i_thresh),
      .i_raw        (i_opto_switch[g]),
      .i_glitch_clr (i_glitch_clr),
      .o_level      (o_opto_switch[g]),
      .o_rise       (o_rise[g]),
      .o_fall       (o_fall[g]),
      .o_glitch_cnt (o_glitch_cnt[g*GLITCH_W +: GLITCH_W])
    );
  end

endmodule
